pwm_duty_capture: RTL
=====================

# pwm_duty_capture

Parametrised multi-channel PWM duty-cycle capture block, the next generation of our single-channel inverse-PWM measurement. It measures high-time per fixed measurement period on NCH PWM inputs, optionally averages over 2^AVG_LOG2 periods, flags channels with no edges, and optionally produces signed pairwise differences such as motor drive (PWM1 − PWM2). It sits between the motor PWM outputs and the physics and verification models, and is also used on-chip for drive self-check.

## Interface
- NCH, 4, number of PWM channels; must be even when DIFF=1
- W, 11, duty width; measurement period is 2^W clocks
- AVG_LOG2, 0, averaging depth exponent; output is the mean of 2^AVG_LOG2 periods
- DIFF, 0, 1 enables pairwise difference outputs
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  measurement enable
- pwm_in  in  NCH  raw PWM inputs
- duty_out  out  NCH*W  per-channel duty; channel i occupies [i*W +: W]
- vld  out  1  one-cycle pulse; duty_out and stuck flags are new this cycle
- stuck_hi  out  NCH  no rising edge in the last window, and the level is high
- stuck_lo  out  NCH  no rising edge in the last window, and the level is low
- diff_out  out  (NCH/2)*(W+1)  signed duty[2k] − duty[2k+1]; pair k occupies [k*(W+1) +: W+1]
- diff_vld  out  1  one-cycle pulse; diff_out is new this cycle

## Operation
- pwm_in passes through a 2-flop synchronizer per channel. All logic uses the synchronized level `s`.
- per_cnt is a W-bit free-running counter. A period ends (`pe`) in the cycle where per_cnt is all ones.
- hi_cnt[i] (W bits):
  - cleared on `pe`;
  - otherwise increments when s[i]=1;
  - the sample in the `pe` cycle is discarded, so the maximum value is 2^W−1 and the counter never overflows.
- Averaging window:
  - avg_cnt (AVG_LOG2 bits) counts periods;
  - acc[i] is W+AVG_LOG2 bits.
- On `pe` with avg_cnt not at its terminal value:
  - acc[i] += hi_cnt[i];
  - avg_cnt increments.
- On `pe` with avg_cnt at its terminal value (always true when AVG_LOG2=0):
  - duty_out[i] <= (acc[i]+hi_cnt[i]) >> AVG_LOG2, truncating;
  - acc and avg_cnt clear.
- Edge tracking:
  - edge_seen[i] sets on a rising edge of s[i];
  - it clears at each window update.
- At a window update:
  - stuck_hi[i] <= ~edge_seen[i] & s[i];
  - stuck_lo[i] <= ~edge_seen[i] & ~s[i].
- DIFF=1:
  - on the cycle after vld, diff_out[k] <= sign-extended duty[2k] − duty[2k+1] (W+1 bits, never overflows);
  - diff_vld pulses that cycle.
- DIFF=0: diff_out and diff_vld are tied to 0.
- en=0:
  - per_cnt, hi_cnt, acc, avg_cnt and edge_seen are held at 0;
  - vld and diff_vld are 0;
  - duty_out, stuck and diff outputs hold their last values.
- On en rising, measurement restarts with per_cnt=0.

## Timing
- Reset values: every output is 0; per_cnt, hi_cnt, acc, avg_cnt, edge_seen and the synchronizers are 0.
- With en=1 and rst released, the first vld is high after clock edge 2^(W+AVG_LOG2) counted from release. After that, vld fires every 2^(W+AVG_LOG2) clocks.
- vld is asserted in the same cycle that duty_out and the stuck flags first show new values.
- diff_vld and diff_out follow vld by exactly 1 cycle.
- Input-to-count latency is 2 clocks (synchronizer).
- rst during a window aborts it: all state clears and nothing partial is reported. Timing restarts as for first release.
- rst overrides en.
- en dropping on a `pe` cycle: no update and no vld; duty_out holds.
- Simultaneous rising edge and window update on a channel: the edge counts for the current window. edge_seen is then cleared for the next window.

## Test plan
- NCH=4, W=11, AVG_LOG2=0. ch0 held high, ch1 held low, ch2 is a 50% square wave with period 256:
  - from the second vld on: duty ch0=2047, ch1=0, ch2=1024;
  - stuck_hi=4'b0001, stuck_lo=4'b1010 after masking ch3.
- Aligned PWM with period 2048 and 512 high clocks placed mid-period: duty_out=512 at the second and every later vld; vld spacing is exactly 2048 clocks.
- AVG_LOG2=2 with per-period high counts 100, 200, 300, 401: duty=250 (1001>>2); vld spacing 8192; no vld on the intermediate period ends.
- DIFF=1 with ch0=1500, ch1=300:
  - diff_out[0]=+1200, with diff_vld one cycle after vld;
  - swapping the channels gives 12'hB50 (−1200).
- rst pulsed for 1 cycle at per_cnt=1000:
  - all outputs read 0 the next cycle;
  - the next vld comes exactly 2048 clocks after release.
- en held low for 5000 clocks: no vld, duty_out holds its last value. After en rises, the first vld comes after 2048 clocks.

Source files
------------

// File: rtl/pwm_duty_capture.sv
// pwm_duty_capture: multi-channel PWM high-time measurement.
// Each channel's synchronized level is counted over a 2^W clock period. The counts can be
// averaged over 2^AVG_LOG2 periods. The block flags channels that saw no rising edge in a
// window, and can optionally report signed pairwise differences.
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   en_i         measurement enable; low holds all counters at zero
//   pwm_in_i     raw PWM inputs, one bit per channel
//   duty_out_o   per-channel duty, channel i at [i*W +: W]
//   vld_o        one-cycle pulse when duty_out_o and the stuck flags update
//   stuck_hi_o   no rising edge in the last window, and the level is high
//   stuck_lo_o   no rising edge in the last window, and the level is low
//   diff_out_o   signed duty[2k] - duty[2k+1], pair k at [k*(W+1) +: W+1]
//   diff_vld_o   one-cycle pulse, one cycle after vld_o, when diff_out_o updates
module pwm_duty_capture #(
  parameter int unsigned NCH      = 4,
  parameter int unsigned W        = 11,
  parameter int unsigned AVG_LOG2 = 0,
  parameter int unsigned DIFF     = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic [NCH-1:0]           pwm_in_i,
  output logic [NCH*W-1:0]         duty_out_o,
  output logic                     vld_o,
  output logic [NCH-1:0]           stuck_hi_o,
  output logic [NCH-1:0]           stuck_lo_o,
  output logic [(NCH/2)*(W+1)-1:0] diff_out_o,
  output logic                     diff_vld_o
);
  localparam int unsigned AW = W + AVG_LOG2;
  localparam int unsigned CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned NP = NCH / 2;

  logic [NCH-1:0]         s1_q, s_q, s_prev_q, rise;
  logic [W-1:0]           per_q, per_d;
  logic [NCH-1:0][W-1:0]  hi_q, hi_d;
  logic [NCH-1:0][AW-1:0] acc_q, acc_d, win_sum;
  logic [CW-1:0]          avg_q, avg_d;
  logic [NCH-1:0]         edge_q, edge_d, seen;
  logic [NCH-1:0][W-1:0]  duty_q, duty_d;
  logic [NCH-1:0]         shi_q, shi_d, slo_q, slo_d;
  logic                   vld_q, vld_d;
  logic                   pe, avg_term;

  assign rise     = s_q & ~s_prev_q;
  assign pe       = en_i & (per_q == {W{1'b1}});
  assign avg_term = (AVG_LOG2 == 0) ? 1'b1 : (avg_q == {CW{1'b1}});
  // A rising edge in the update cycle still belongs to the window being closed.
  assign seen     = edge_q | rise;

  always_comb begin
    win_sum = '0;
    for (int i = 0; i < NCH; i++) begin
      win_sum[i] = acc_q[i] + AW'(hi_q[i]);
    end
  end

  always_comb begin
    per_d  = '0;
    hi_d   = '0;
    acc_d  = '0;
    avg_d  = '0;
    edge_d = '0;
    duty_d = duty_q;
    shi_d  = shi_q;
    slo_d  = slo_q;
    vld_d  = 1'b0;
    if (en_i) begin
      per_d  = per_q + 1'b1;
      acc_d  = acc_q;
      avg_d  = avg_q;
      edge_d = seen;
      if (pe) begin
        // Sample in the period-end cycle is dropped so hi_cnt tops out at 2^W-1.
        hi_d = '0;
        if (avg_term) begin
          for (int i = 0; i < NCH; i++) begin
            duty_d[i] = W'(win_sum[i] >> AVG_LOG2);
          end
          acc_d  = '0;
          avg_d  = '0;
          edge_d = '0;
          shi_d  = ~seen & s_q;
          slo_d  = ~seen & ~s_q;
          vld_d  = 1'b1;
        end else begin
          acc_d = win_sum;
          avg_d = avg_q + 1'b1;
        end
      end else begin
        for (int i = 0; i < NCH; i++) begin
          hi_d[i] = hi_q[i] + W'(s_q[i]);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q     <= '0;
      s_q      <= '0;
      s_prev_q <= '0;
      per_q    <= '0;
      hi_q     <= '0;
      acc_q    <= '0;
      avg_q    <= '0;
      edge_q   <= '0;
      duty_q   <= '0;
      shi_q    <= '0;
      slo_q    <= '0;
      vld_q    <= 1'b0;
    end else begin
      s1_q     <= pwm_in_i;
      s_q      <= s1_q;
      s_prev_q <= s_q;
      per_q    <= per_d;
      hi_q     <= hi_d;
      acc_q    <= acc_d;
      avg_q    <= avg_d;
      edge_q   <= edge_d;
      duty_q   <= duty_d;
      shi_q    <= shi_d;
      slo_q    <= slo_d;
      vld_q    <= vld_d;
    end
  end

  assign duty_out_o = duty_q;
  assign stuck_hi_o = shi_q;
  assign stuck_lo_o = slo_q;
  assign vld_o      = vld_q & en_i;

  if (DIFF != 0 && NP > 0) begin : g_diff
    logic [NP-1:0][W:0] diff_q, diff_d;
    logic               dvld_q;

    // W+1 bits hold any difference of two W-bit unsigned values.
    always_comb begin
      diff_d = diff_q;
      if (vld_o) begin
        for (int k = 0; k < NP; k++) begin
          diff_d[k] = {1'b0, duty_q[2*k]} - {1'b0, duty_q[2*k+1]};
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        diff_q <= '0;
        dvld_q <= 1'b0;
      end else begin
        diff_q <= diff_d;
        dvld_q <= vld_o;
      end
    end

    assign diff_out_o = diff_q;
    assign diff_vld_o = dvld_q & en_i;
  end else begin : g_no_diff
    assign diff_out_o = '0;
    assign diff_vld_o = 1'b0;
  end

endmodule
